adder_limb_seq: RTL

//   Multi-precision add sequencer that sits directly upstream of `adder`.
//   - Accepts one wide operand pair per transaction.
//   - Feeds it to `adder` one WIDTH-bit limb per cycle, LSB limb first.
//   - Chains the carry out of each limb (add_sm[WIDTH]) into add_cin of the next limb.
//   - Assembles the wide sum and presents it on a valid/ready output.

---
 rtl/adder_pkg.sv | 19 +
 rtl/adder_limb_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the multi-limb add sequencer.
package adder_pkg;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Limb index width: $clog2(nlimbs), never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned nlimbs);
        return (nlimbs > 1) ? $clog2(nlimbs) : 1;
    endfunction

    localparam int unsigned DEFAULT_NLIMBS = 4;
    localparam int unsigned DEFAULT_IDXW   = idx_width(DEFAULT_NLIMBS);

endpackage

// File: rtl/adder_limb_seq.sv
// Multi-precision add sequencer: feeds one limb per cycle to an external
// combinational adder (LSB limb first), chains the carry, and returns the
// assembled wide sum on a valid/ready output.
module adder_limb_seq
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SWIDTH = WIDTH + 1,
    parameter int unsigned NLIMBS = 4,
    parameter int unsigned TOTW   = WIDTH * NLIMBS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TOTW-1:0]   in_a,
    input  logic [TOTW-1:0]   in_b,
    input  logic              in_cin,
    output logic [WIDTH-1:0]  add_x,
    output logic [WIDTH-1:0]  add_y,
    output logic              add_cin,
    input  logic [SWIDTH-1:0] add_sm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TOTW-1:0]   out_sum,
    output logic              out_cout,
    output logic              out_zero
);

    localparam int unsigned     IDXW     = idx_width(NLIMBS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NLIMBS - 1);

    // Parameter sanity checks at elaboration
    if (SWIDTH != WIDTH + 1) begin : g_bad_swidth
        $error("adder_limb_seq: SWIDTH must equal WIDTH+1");
    end
    if (NLIMBS < 1) begin : g_bad_nlimbs
        $error("adder_limb_seq: NLIMBS must be >= 1");
    end
    if (TOTW != WIDTH * NLIMBS) begin : g_bad_totw
        $error("adder_limb_seq: TOTW must equal WIDTH*NLIMBS");
    end

    state_t            state_q,     state_d;
    logic [IDXW-1:0]   idx_q,       idx_d;
    logic [TOTW-1:0]   a_q,         a_d;
    logic [TOTW-1:0]   b_q,         b_d;
    logic [TOTW-1:0]   sum_q,       sum_d;
    logic              carry_q,     carry_d;
    logic              in_ready_d;
    logic [WIDTH-1:0]  add_x_d,     add_y_d;
    logic              add_cin_d;
    logic              out_valid_d, out_cout_d, out_zero_d;
    logic [TOTW-1:0]   out_sum_d;
    logic [TOTW-1:0]   sum_next;

    // Next-state and next-output logic; operand registers shift down one limb
    // per RUN cycle so the next limb is always at the LSBs, and the sum shifts
    // in from the top so limb 0 lands at the bottom after NLIMBS steps.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        in_ready_d  = in_ready;
        add_x_d     = '0;
        add_y_d     = '0;
        add_cin_d   = 1'b0;
        out_valid_d = out_valid;
        out_sum_d   = out_sum;
        out_cout_d  = out_cout;
        out_zero_d  = out_zero;
        sum_next    = (sum_q >> WIDTH) | (TOTW'(add_sm[WIDTH-1:0]) << (TOTW - WIDTH));

        unique case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid) begin
                    a_d        = in_a >> WIDTH;
                    b_d        = in_b >> WIDTH;
                    carry_d    = in_cin;
                    idx_d      = '0;
                    sum_d      = '0;
                    add_x_d    = in_a[WIDTH-1:0];
                    add_y_d    = in_b[WIDTH-1:0];
                    add_cin_d  = in_cin;
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d = add_sm[WIDTH];
                sum_d   = sum_next;
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_sum_d   = sum_next;
                    out_cout_d  = add_sm[WIDTH];
                    out_zero_d  = (sum_next == '0) && !add_sm[WIDTH];
                end else begin
                    idx_d     = idx_q + IDXW'(1);
                    add_x_d   = a_q[WIDTH-1:0];
                    add_y_d   = b_q[WIDTH-1:0];
                    add_cin_d = add_sm[WIDTH];
                    a_d       = a_q >> WIDTH;
                    b_d       = b_q >> WIDTH;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            in_ready  <= 1'b1;
            add_x     <= '0;
            add_y     <= '0;
            add_cin   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            in_ready  <= in_ready_d;
            add_x     <= add_x_d;
            add_y     <= add_y_d;
            add_cin   <= add_cin_d;
            out_valid <= out_valid_d;
            out_sum   <= out_sum_d;
            out_cout  <= out_cout_d;
            out_zero  <= out_zero_d;
        end
    end

endmodule
